// File: rtl/freq_duty_meter.sv
// rtl/freq_duty_meter.sv - gated frequency and duty-cycle meter for an asynchronous input.
// Counts rising edges and high cycles per window, then derives duty percent by restoring division.
module freq_duty_meter #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned GATE_CYCLES = CLK_FREQ,
  parameter int unsigned FREQ_W      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              signal_in,
  output logic [FREQ_W-1:0] freq,
  output logic [6:0]        duty_pct,
  output logic              freq_ovf,
  output logic              valid
);

  localparam logic [31:0]       LP_LAST     = 32'(GATE_CYCLES - 1);
  localparam logic [38:0]       LP_DIVISOR  = 39'(GATE_CYCLES);
  localparam logic [FREQ_W-1:0] LP_EDGE_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

  logic              r_sync1;
  logic              r_sig_s;
  logic              r_sig_d;
  logic [31:0]       r_gate;
  logic [31:0]       r_high_cnt;
  logic [FREQ_W-1:0] r_edge_cnt;
  logic              r_ovf;
  state_t            r_state;
  logic [2:0]        r_iter;
  logic [38:0]       r_rem;
  logic [6:0]        r_quot;
  logic [FREQ_W-1:0] r_freq_snap;
  logic              r_ovf_snap;

  logic              w_edge;
  logic              w_close;
  logic              w_edge_sat;
  logic [FREQ_W-1:0] w_edge_next;
  logic              w_ovf_next;
  logic [31:0]       w_high_next;
  logic [38:0]       w_dividend;
  logic [38:0]       w_trial;

  assign w_edge      = r_sig_s & ~r_sig_d;
  assign w_close     = (r_gate == LP_LAST);
  assign w_edge_sat  = (r_edge_cnt == LP_EDGE_MAX);
  assign w_edge_next = (w_edge && !w_edge_sat) ? r_edge_cnt + 1'b1 : r_edge_cnt;
  assign w_ovf_next  = r_ovf | (w_edge & w_edge_sat);
  assign w_high_next = r_high_cnt + {31'd0, r_sig_s};
  assign w_dividend  = 39'(w_high_next) * 39'd100;
  assign w_trial     = LP_DIVISOR << r_iter;

  // The "next" values fold in the closing cycle so an edge on the last cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sig_s    <= 1'b0;
      r_sig_d    <= 1'b0;
      r_gate     <= 32'd0;
      r_high_cnt <= 32'd0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_sync1 <= signal_in;
      r_sig_s <= r_sync1;
      r_sig_d <= r_sig_s;
      if (w_close) begin
        r_gate     <= 32'd0;
        r_high_cnt <= 32'd0;
        r_edge_cnt <= '0;
        r_ovf      <= 1'b0;
      end else begin
        r_gate     <= r_gate + 32'd1;
        r_high_cnt <= w_high_next;
        r_edge_cnt <= w_edge_next;
        r_ovf      <= w_ovf_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_iter      <= 3'd0;
      r_rem       <= 39'd0;
      r_quot      <= 7'd0;
      r_freq_snap <= '0;
      r_ovf_snap  <= 1'b0;
      freq        <= '0;
      duty_pct    <= 7'd0;
      freq_ovf    <= 1'b0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_close) begin
            r_freq_snap <= w_edge_next;
            r_ovf_snap  <= w_ovf_next;
            r_rem       <= w_dividend;
            r_quot      <= 7'd0;
            r_iter      <= 3'd6;
            r_state     <= S_DIV;
          end
        end
        S_DIV: begin
          if (r_rem >= w_trial) begin
            r_rem          <= r_rem - w_trial;
            r_quot[r_iter] <= 1'b1;
          end
          if (r_iter == 3'd0) begin
            r_state <= S_OUT;
          end else begin
            r_iter <= r_iter - 3'd1;
          end
        end
        S_OUT: begin
          freq     <= r_freq_snap;
          freq_ovf <= r_ovf_snap;
          duty_pct <= (r_quot > 7'd100) ? 7'd100 : r_quot;
          valid    <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/freq_duty_meter.md
FREQ_DUTY_METER -- requirements
Module: freq_duty_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz (informational; default for GATE_CYCLES).
REQ-002 SHALL have parameter GATE_CYCLES, default CLK_FREQ, measurement window length in clocks; legal range 16 to 2^32-1.
REQ-003 SHALL have parameter FREQ_W, default 20, width of frequency result.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port signal_in  input  1  asynchronous measured signal.
REQ-007 SHALL have port freq  output  FREQ_W  rising edges counted in the last completed window (Hz when GATE_CYCLES = CLK_FREQ).
REQ-008 SHALL have port duty_pct  output  7  high time of last window, in percent, 0..100.
REQ-009 SHALL have port freq_ovf  output  1  last window edge count exceeded 2^FREQ_W-1.
REQ-010 SHALL have port valid  output  1  one-cycle pulse: freq/duty_pct/freq_ovf updated this cycle.

Function
REQ-011 SHALL pass signal_in through a 2-flop synchronizer; sig_s = second flop output; third flop sig_d holds the previous sig_s.
REQ-012 SHALL detect a rising edge as sig_s=1 and sig_d=0; one edge counts once.
REQ-013 SHALL run a gate counter 0..GATE_CYCLES-1 that wraps with no dead cycles; the first window starts on the first clk after rst_n deasserts.
REQ-014 SHALL increment edge_cnt on every detected edge in the window, including edges in the last cycle; saturate at 2^FREQ_W-1 and set the window overflow flag on any further edge.
REQ-015 SHALL increment high_cnt (32 bits) on every window cycle with sig_s=1.
REQ-016 SHALL, at window close (gate counter = GATE_CYCLES-1), snapshot edge_cnt, overflow flag and high_cnt on that edge; clear the live counters so the next window counts from 0.
REQ-017 SHALL use a state machine: IDLE (wait for snapshot), DIV (7 iterations), OUT (publish); IDLE->DIV on snapshot, DIV->OUT after iteration 7, OUT->IDLE unconditionally.
REQ-018 SHALL compute duty_pct = floor(high_cnt*100 / GATE_CYCLES) by restoring division: dividend is 39 bits; for i = 6 down to 0, if remainder >= GATE_CYCLES<<i, subtract and set quotient bit i.
REQ-019 SHALL assert valid and update freq, freq_ovf and duty_pct together, exactly 8 clocks after the snapshot edge; valid SHALL be high for exactly one cycle per window.
REQ-020 SHALL hold the outputs between valid pulses.
REQ-021 SHALL finish the division before the next snapshot (guaranteed by GATE_CYCLES >= 16); no result SHALL be lost or merged.
REQ-022 SHALL give, for a constant-low signal: freq=0, duty_pct=0; constant high: freq=0, duty_pct=100 (an edge at window start counts 1).
REQ-023 SHALL clamp duty_pct to 100 (cannot exceed by construction; clamp is defensive).

Reset
REQ-024 SHALL, while rst_n=0, force freq=0, duty_pct=0, freq_ovf=0, valid=0, synchronizer flops=0, all counters=0, state=IDLE.
REQ-025 SHALL abort any window or division in progress on reset, with no valid pulse for it; after release, the first valid arrives GATE_CYCLES+8 clocks later.

Verification (GATE_CYCLES=1000, FREQ_W=8 unless stated)
REQ-026 Period 100 clocks, 30 high, free-running -> each valid: freq=10, duty_pct=30, freq_ovf=0; valid pulses exactly 1000 clocks apart.
REQ-027 signal_in held 0, then held 1 -> freq=0/duty_pct=0; on the first window after the change, freq=1 and duty_pct <= 100; on later windows freq=0, duty_pct=100.
REQ-028 Period 2 clocks (500 edges) with FREQ_W=8 -> freq=255, freq_ovf=1; return to period 100 -> next full window has freq=10, freq_ovf=0.
REQ-029 Period 3 clocks, 1 high -> duty_pct=33 (floor), freq=333 with FREQ_W=10.
REQ-030 rst_n pulsed low 3 clocks during DIV state -> no valid for that window, outputs 0 during reset, next valid exactly 1008 clocks after release with correct values.
